// File: rtl/neuron_folded_nbits.sv
// neuron_folded_nbits
//   Folded N-bit neuron. A vector of N_INPUTS weight/input pairs arrives as
//   N_INPUTS/P beats of P lanes each. Each beat's P products are added into a
//   wide signed accumulator seeded with the vector's bias. After the last beat,
//   the accumulator is arithmetically shifted right by SHIFT and passed through
//   the selected activation. The N-bit result is then held on a valid/ready port.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   in_valid_i    beat on w_chunk_i/x_chunk_i/bias_i/mode_i is valid
//   in_ready_o    block accepts a beat this cycle (decoded from state only)
//   w_chunk_i     P packed signed weights, lane i at [i*N +: N]
//   x_chunk_i     P packed signed inputs, lane i at [i*N +: N]
//   bias_i        signed bias, used only on the first beat of a vector
//   mode_i        0 = saturated ReLU, 1 = signed saturate; used on first beat
//   out_valid_o   result available (decoded from state only)
//   out_ready_i   consumer takes the result
//   out_o         signed activated result (registered)
//   sat_o         result was clamped to MAX or MIN (registered)
module neuron_folded_nbits #(
  parameter int N        = 8,
  parameter int N_INPUTS = 32,
  parameter int P        = 4,
  parameter int SHIFT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N*P-1:0]        w_chunk_i,
  input  logic [N*P-1:0]        x_chunk_i,
  input  logic signed [N-1:0]   bias_i,
  input  logic                  mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic signed [N-1:0]   out_o,
  output logic                  sat_o
);

  // Accumulator width: wide enough for N_INPUTS full products plus the bias.
  localparam int ACC_W  = 2*N + $clog2(N_INPUTS) + 1;
  localparam int PSUM_W = 2*N + $clog2(P);
  localparam int BEATS  = N_INPUTS / P;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  // Activation bounds at accumulator width and at result width.
  localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [N-1:0]     MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]     MIN_N = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_ACT   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      mode_q, mode_d;
  logic signed [N-1:0]       out_q, out_d;
  logic                      sat_q, sat_d;

  logic signed [2*N-1:0]     prod_s [P];
  logic signed [PSUM_W-1:0]  psum_s;
  logic signed [ACC_W-1:0]   r_s;
  logic signed [N-1:0]       act_out_s;
  logic                      act_sat_s;

  // Full-precision lane products; assignment context gives the 2N-bit multiply.
  for (genvar g = 0; g < P; g++) begin : g_lane
    assign prod_s[g] = $signed(w_chunk_i[g*N +: N]) * $signed(x_chunk_i[g*N +: N]);
  end

  // Sum of the lane products, each sign-extended to the partial-sum width.
  always_comb begin
    psum_s = '0;
    for (int i = 0; i < P; i++) begin
      psum_s = psum_s + PSUM_W'(prod_s[i]);
    end
  end

  // Fixed-point shift followed by the selected activation.
  always_comb begin
    r_s       = acc_q >>> SHIFT;
    act_out_s = r_s[N-1:0];
    act_sat_s = 1'b0;
    if (mode_q == 1'b0) begin
      if (r_s[ACC_W-1]) begin
        act_out_s = '0;
        act_sat_s = 1'b0;
      end else if (r_s > MAX_A) begin
        act_out_s = MAX_N;
        act_sat_s = 1'b1;
      end else begin
        act_out_s = r_s[N-1:0];
        act_sat_s = 1'b0;
      end
    end else begin
      if (r_s > MAX_A) begin
        act_out_s = MAX_N;
        act_sat_s = 1'b1;
      end else if (r_s < MIN_A) begin
        act_out_s = MIN_N;
        act_sat_s = 1'b1;
      end else begin
        act_out_s = r_s[N-1:0];
        act_sat_s = 1'b0;
      end
    end
  end

  // Next-state and datapath update; every register holds unless changed below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    out_d   = out_q;
    sat_d   = sat_q;
    case (state_q)
      ST_ACCUM: begin
        // in_ready is high in this state, so in_valid alone means acceptance.
        if (in_valid_i) begin
          if (cnt_q == '0) begin
            acc_d  = ACC_W'(bias_i) + ACC_W'(psum_s);
            mode_d = mode_i;
          end else begin
            acc_d  = acc_q + ACC_W'(psum_s);
          end
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_ACT;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACT: begin
        out_d   = act_out_s;
        sat_d   = act_sat_s;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  // Handshake flags depend only on the state register.
  assign in_ready_o  = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_HOLD);
  assign out_o       = out_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_neuron_folded_nbits.sv
module tb_neuron_folded_nbits;

  localparam int N = 8;
  localparam int N_INPUTS = 32;
  localparam int P = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic [N*P-1:0]      w_chunk;
  logic [N*P-1:0]      x_chunk;
  logic signed [N-1:0] bias;
  logic                mode;
  logic                out_ready;

  logic                in_ready, out_valid, sat;
  logic signed [N-1:0] out;
  logic                in_ready2, out_valid2, sat2;
  logic signed [N-1:0] out2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int e0;
    int s0;
    int e2;
    int s2;
  } exp_t;
  exp_t sb_q[$];

  neuron_folded_nbits #(.N(N), .N_INPUTS(N_INPUTS), .P(P), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .w_chunk_i(w_chunk), .x_chunk_i(x_chunk),
    .bias_i(bias), .mode_i(mode),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_o(out), .sat_o(sat)
  );

  neuron_folded_nbits #(.N(N), .N_INPUTS(N_INPUTS), .P(P), .SHIFT(2)) u_dut_s2 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .w_chunk_i(w_chunk), .x_chunk_i(x_chunk),
    .bias_i(bias), .mode_i(mode),
    .out_valid_o(out_valid2), .out_ready_i(out_ready),
    .out_o(out2), .sat_o(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic push_exp(input int e0, input int s0, input int e2, input int s2);
    exp_t e;
    e.e0 = e0; e.s0 = s0; e.e2 = e2; e.s2 = s2;
    sb_q.push_back(e);
  endtask

  // Drives nb beats of constant-lane operands; bias/mode differ after beat 0.
  task automatic send_vec(input logic signed [7:0] w, input logic signed [7:0] x,
                          input logic signed [7:0] b0, input logic signed [7:0] bl,
                          input logic md, input int nb, input bit gaps, input bit chk_lat);
    for (int i = 0; i < nb; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      w_chunk  = {P{w}};
      x_chunk  = {P{x}};
      bias     = (i == 0) ? b0 : bl;
      mode     = (i == 0) ? md : ~md;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !in_ready; t++) begin @(posedge clk); #1; end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (chk_lat) begin
      check("lat_act_valid", out_valid, 0);
      @(posedge clk); #1;
      check("lat_hold_valid", out_valid, 1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) check("idle_timeout", in_ready, 1);
  endtask

  // Scoreboard monitor: compares whenever the output handshake completes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected none", out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out", out, e.e0);
        check("sat", sat, e.s0);
        check("valid_s2", out_valid2, 1);
        check("out_s2", out2, e.e2);
        check("sat_s2", sat2, e.s2);
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; w_chunk = '0; x_chunk = '0;
    bias = '0; mode = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sat", sat, 0);
    check("rst_in_ready", in_ready, 1);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    push_exp(96, 0, 24, 0);      send_vec(1, 3, 0, 0, 1'b0, 8, 0, 1);        wait_idle();
    push_exp(127, 1, 127, 1);    send_vec(127, 127, 0, 0, 1'b0, 8, 0, 0);    wait_idle();
    push_exp(-128, 1, -128, 1);  send_vec(-128, 127, 0, 0, 1'b1, 8, 0, 0);   wait_idle();
    push_exp(0, 0, 0, 0);        send_vec(-128, 127, 0, 0, 1'b0, 8, 0, 0);   wait_idle();
    push_exp(-8, 0, -2, 0);      send_vec(1, 1, -40, 100, 1'b1, 8, 0, 0);    wait_idle();
    push_exp(0, 0, 0, 0);        send_vec(1, 1, -40, 100, 1'b0, 8, 0, 0);    wait_idle();
    push_exp(96, 0, 24, 0);      send_vec(1, 3, 0, 0, 1'b0, 8, 1, 0);        wait_idle();

    // Consumer stalls: result must hold and further beats must be refused.
    out_ready = 1'b0;
    push_exp(69, 0, 17, 0);      send_vec(2, 1, 5, 5, 1'b1, 8, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; w_chunk = {P{8'sd127}}; x_chunk = {P{8'sd127}};
      check("stall_out", out, 69);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Back-to-back vectors.
    push_exp(-96, 0, -24, 0);
    push_exp(106, 0, 26, 0);
    send_vec(-1, 3, 0, 0, 1'b1, 8, 0, 0);
    send_vec(1, 3, 10, 10, 1'b1, 8, 0, 0);
    wait_idle();

    // Reset mid-vector after 3 accepted beats.
    send_vec(127, 127, 0, 0, 1'b0, 3, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", out, 0);
    check("midrst_out_s2", out2, 0);
    check("midrst_sat", sat, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    push_exp(127, 1, 32, 0);     send_vec(2, 2, 0, 0, 1'b0, 8, 0, 0);        wait_idle();
    push_exp(127, 1, 32, 0);     send_vec(2, 2, 0, 0, 1'b1, 8, 0, 0);        wait_idle();

    for (int t = 0; t < 200 && sb_q.size() != 0; t++) begin @(posedge clk); #1; end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
